id_ex_fwd_stage: RTL and testbench

- ID/EX pipeline register plus execute-side operand forwarding for the 16-bit pipelined core.
- Captures decoded instruction, register-file operands, extended immediate and control bits from decode.
- Drives the operand inputs (reg1, reg2, Instruction) of the execute ALU, resolving RAW hazards from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble; handles stall and flush.

---
 rtl/id_ex_fwd_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with execute-side operand forwarding from EX/MEM and
// MEM/WB, load-use bubble insertion, stall hold and flush.
module id_ex_fwd_stage #(
   parameter int                 WIDTH     = 16,
   parameter int                 RA_W      = 3,
   parameter logic [WIDTH-1:0]   NOP_INSTR = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [WIDTH-1:0]  id_instr,
   input  logic [WIDTH-1:0]  id_rs_data,
   input  logic [WIDTH-1:0]  id_rt_data,
   input  logic [WIDTH-1:0]  id_imm,
   input  logic              id_use_imm,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [RA_W-1:0]   id_rs_addr,
   input  logic [RA_W-1:0]   id_rt_addr,
   input  logic [RA_W-1:0]   id_rd_addr,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic [WIDTH-1:0]  id_pc_plus2,
   input  logic              exmem_reg_write,
   input  logic [RA_W-1:0]   exmem_rd_addr,
   input  logic [WIDTH-1:0]  exmem_result,
   input  logic              memwb_reg_write,
   input  logic [RA_W-1:0]   memwb_rd_addr,
   input  logic [WIDTH-1:0]  memwb_result,
   output logic              ex_valid,
   output logic [WIDTH-1:0]  ex_instr,
   output logic [WIDTH-1:0]  ex_reg1,
   output logic [WIDTH-1:0]  ex_reg2,
   output logic [WIDTH-1:0]  ex_store_data,
   output logic [RA_W-1:0]   ex_rd_addr,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [WIDTH-1:0]  ex_pc_plus2,
   output logic              load_use_hazard
);

   typedef struct packed {
      logic              valid;
      logic [WIDTH-1:0]  instr;
      logic [WIDTH-1:0]  rs_data;
      logic [WIDTH-1:0]  rt_data;
      logic [WIDTH-1:0]  imm;
      logic              use_imm;
      logic              uses_rs;
      logic              uses_rt;
      logic [RA_W-1:0]   rs_addr;
      logic [RA_W-1:0]   rt_addr;
      logic [RA_W-1:0]   rd_addr;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic [WIDTH-1:0]  pc_plus2;
   } stage_t;

   stage_t           st_q, st_d, bubble_s;
   logic [WIDTH-1:0] fwd_rs, fwd_rt;
   logic             raw_hazard;

   always_comb begin
      bubble_s       = '0;
      bubble_s.instr = NOP_INSTR;
   end

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   always_comb begin
      fwd_rs = st_q.rs_data;
      if (st_q.uses_rs) begin
         if (exmem_reg_write && (exmem_rd_addr == st_q.rs_addr))
            fwd_rs = exmem_result;
         else if (memwb_reg_write && (memwb_rd_addr == st_q.rs_addr))
            fwd_rs = memwb_result;
      end
   end

   always_comb begin
      fwd_rt = st_q.rt_data;
      if (st_q.uses_rt) begin
         if (exmem_reg_write && (exmem_rd_addr == st_q.rt_addr))
            fwd_rt = exmem_result;
         else if (memwb_reg_write && (memwb_rd_addr == st_q.rt_addr))
            fwd_rt = memwb_result;
      end
   end

   always_comb begin
      raw_hazard = st_q.valid & st_q.mem_read & st_q.reg_write & id_valid &
                   ((id_uses_rs & (id_rs_addr == st_q.rd_addr)) |
                    (id_uses_rt & (id_rt_addr == st_q.rd_addr)));
      load_use_hazard = raw_hazard & ~flush & ~stall;
   end

   always_comb begin
      st_d = st_q;
      if (flush) begin
         st_d = bubble_s;
      end else if (stall) begin
         // Refresh operands so a result retiring from MEM/WB mid-stall is kept.
         st_d.rs_data = fwd_rs;
         st_d.rt_data = fwd_rt;
      end else if (load_use_hazard || !id_valid) begin
         st_d = bubble_s;
      end else begin
         st_d.valid     = 1'b1;
         st_d.instr     = id_instr;
         st_d.rs_data   = id_rs_data;
         st_d.rt_data   = id_rt_data;
         st_d.imm       = id_imm;
         st_d.use_imm   = id_use_imm;
         st_d.uses_rs   = id_uses_rs;
         st_d.uses_rt   = id_uses_rt;
         st_d.rs_addr   = id_rs_addr;
         st_d.rt_addr   = id_rt_addr;
         st_d.rd_addr   = id_rd_addr;
         st_d.reg_write = id_reg_write;
         st_d.mem_read  = id_mem_read;
         st_d.mem_write = id_mem_write;
         st_d.pc_plus2  = id_pc_plus2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         st_q <= bubble_s;
      else
         st_q <= st_d;
   end

   assign ex_valid      = st_q.valid;
   assign ex_instr      = st_q.instr;
   assign ex_reg1       = fwd_rs;
   assign ex_reg2       = st_q.use_imm ? st_q.imm : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_rd_addr    = st_q.rd_addr;
   assign ex_reg_write  = st_q.reg_write;
   assign ex_mem_read   = st_q.mem_read;
   assign ex_mem_write  = st_q.mem_write;
   assign ex_pc_plus2   = st_q.pc_plus2;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Scoreboard bench for id_ex_fwd_stage: directed scenarios plus random traffic,
// expectations from an instruction-slot reference model.
module tb_id_ex_fwd_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [15:0] id_instr, id_rs_data, id_rt_data, id_imm, id_pc_plus2;
   logic        id_use_imm, id_uses_rs, id_uses_rt;
   logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        exmem_reg_write, memwb_reg_write;
   logic [2:0]  exmem_rd_addr, memwb_rd_addr;
   logic [15:0] exmem_result, memwb_result;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
   logic [15:0] ex_instr, ex_reg1, ex_reg2, ex_store_data, ex_pc_plus2;
   logic [2:0]  ex_rd_addr;

   always #10 clk = ~clk;

   id_ex_fwd_stage #(.WIDTH(16), .RA_W(3), .NOP_INSTR(16'h0800)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_instr(id_instr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_pc_plus2(id_pc_plus2),
      .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
      .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
      .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
      .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_pc_plus2(ex_pc_plus2),
      .load_use_hazard(load_use_hazard)
   );

   // Instruction occupying the EX slot, as the reference model sees it.
   typedef struct {
      bit          valid;
      logic [15:0] instr, rs, rt, imm, pc;
      bit          use_imm, uses_rs, uses_rt, rw, mr, mw;
      logic [2:0]  ra, rb, rd;
   } slot_t;

   typedef struct {
      logic        valid, rw, mr, mw, luh;
      logic [15:0] instr, reg1, reg2, sd, pc;
      logic [2:0]  rd;
   } exp_t;

   slot_t m;
   exp_t  sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    done     = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic slot_t empty_slot();
      slot_t s;
      s = '{default: '0};
      s.instr = 16'h0800;
      return s;
   endfunction

   // Value an operand register holds at EX time, given the in-flight writers.
   function automatic logic [15:0] resolve(input bit uses, input logic [2:0] a,
                                           input logic [15:0] raw);
      if (!uses) return raw;
      if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
      if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
      return raw;
   endfunction

   task automatic idle();
      rst = 0; stall = 0; flush = 0; id_valid = 0;
      id_instr = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_pc_plus2 = '0;
      id_use_imm = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      exmem_reg_write = 0; exmem_rd_addr = '0; exmem_result = '0;
      memwb_reg_write = 0; memwb_rd_addr = '0; memwb_result = '0;
   endtask

   task automatic set_id(input logic [15:0] instr, input logic [15:0] rsd, input logic [15:0] rtd,
                         input bit urs, input bit urt, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input bit rw, input bit mr);
      id_valid = 1; id_instr = instr; id_rs_data = rsd; id_rt_data = rtd;
      id_uses_rs = urs; id_uses_rt = urt; id_rs_addr = ra; id_rt_addr = rb; id_rd_addr = rd;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_use_imm = 0; id_imm = '0;
      id_pc_plus2 = 16'h0102;
   endtask

   // Push this cycle's expected outputs, then advance the model over one clock edge.
   task automatic step();
      exp_t  e;
      slot_t nm;
      logic [15:0] r1, r2;
      bit hz;
      r1 = resolve(m.uses_rs, m.ra, m.rs);
      r2 = resolve(m.uses_rt, m.rb, m.rt);
      hz = m.valid && m.mr && m.rw && id_valid && !flush && !stall &&
           ((id_uses_rs && id_rs_addr == m.rd) || (id_uses_rt && id_rt_addr == m.rd));
      e.valid = m.valid; e.instr = m.instr; e.reg1 = r1;
      e.reg2 = m.use_imm ? m.imm : r2; e.sd = r2; e.pc = m.pc; e.rd = m.rd;
      e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.luh = hz;
      sb.push_back(e);
      if (rst || flush) nm = empty_slot();
      else if (stall) begin nm = m; nm.rs = r1; nm.rt = r2; end
      else if (hz || !id_valid) nm = empty_slot();
      else begin
         nm.valid = 1; nm.instr = id_instr; nm.rs = id_rs_data; nm.rt = id_rt_data;
         nm.imm = id_imm; nm.pc = id_pc_plus2; nm.use_imm = id_use_imm;
         nm.uses_rs = id_uses_rs; nm.uses_rt = id_uses_rt; nm.rw = id_reg_write;
         nm.mr = id_mem_read; nm.mw = id_mem_write; nm.ra = id_rs_addr;
         nm.rb = id_rt_addr; nm.rd = id_rd_addr;
      end
      @(posedge clk);
      m = nm;
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 20);
      id_valid = ($urandom_range(0, 99) < 80);
      id_instr = 16'($urandom); id_rs_data = 16'($urandom); id_rt_data = 16'($urandom);
      id_imm = 16'($urandom); id_pc_plus2 = 16'($urandom);
      id_use_imm = 1'($urandom); id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_rs_addr = 3'($urandom); id_rt_addr = 3'($urandom); id_rd_addr = 3'($urandom);
      id_mem_read = ($urandom_range(0, 99) < 35);
      id_reg_write = id_mem_read | 1'($urandom);
      id_mem_write = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd_addr = 3'($urandom); exmem_result = 16'($urandom);
      memwb_reg_write = 1'($urandom); memwb_rd_addr = 3'($urandom); memwb_result = 16'($urandom);
   endtask

   // Monitor: the stage presents a result every cycle; compare mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         #8;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("valid", 16'(ex_valid), 16'(e.valid));
            chk("instr", ex_instr, e.instr);
            chk("reg_write", 16'(ex_reg_write), 16'(e.rw));
            chk("mem_read", 16'(ex_mem_read), 16'(e.mr));
            chk("mem_write", 16'(ex_mem_write), 16'(e.mw));
            chk("load_use", 16'(load_use_hazard), 16'(e.luh));
            if (e.valid) begin
               chk("reg1", ex_reg1, e.reg1);
               chk("reg2", ex_reg2, e.reg2);
               chk("store_data", ex_store_data, e.sd);
               chk("rd_addr", 16'(ex_rd_addr), 16'(e.rd));
               chk("pc_plus2", ex_pc_plus2, e.pc);
            end
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m = empty_slot();
      rst = 0;
      #2;
      chk("reset valid", 16'(ex_valid), 16'h0000);
      chk("reset instr", ex_instr, 16'h0800);
      chk("reset ctrl", {13'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 16'h0000);
      chk("reset luh", 16'(load_use_hazard), 16'h0000);
      step();

      // Plain capture
      set_id(16'hD9A0, 16'h0005, 16'h0003, 1, 1, 3'd1, 3'd2, 3'd3, 1, 0);
      step();
      idle(); #2;
      chk("add reg1", ex_reg1, 16'h0005);
      chk("add reg2", ex_reg2, 16'h0003);
      chk("add valid", 16'(ex_valid), 16'h0001);
      step();

      // Forward priority
      set_id(16'hD9A0, 16'h0009, 16'h0001, 1, 0, 3'd2, 3'd6, 3'd4, 1, 0);
      step();
      idle();
      exmem_reg_write = 1; exmem_rd_addr = 3'd2; exmem_result = 16'h1111;
      memwb_reg_write = 1; memwb_rd_addr = 3'd2; memwb_result = 16'h2222;
      #2; chk("fwd exmem wins", ex_reg1, 16'h1111);
      exmem_reg_write = 0;
      #1; chk("fwd memwb", ex_reg1, 16'h2222);
      step();

      // Immediate path
      set_id(16'h5C3E, 16'h0001, 16'h0000, 1, 1, 3'd1, 3'd4, 3'd5, 1, 0);
      id_use_imm = 1; id_imm = 16'hFFFE;
      step();
      idle();
      exmem_reg_write = 1; exmem_rd_addr = 3'd4; exmem_result = 16'h7777;
      #2;
      chk("imm reg2", ex_reg2, 16'hFFFE);
      chk("imm store_data", ex_store_data, 16'h7777);
      step();

      // Load-use bubble
      set_id(16'h8C60, 16'h0000, 16'h0000, 1, 0, 3'd0, 3'd0, 3'd3, 1, 1);
      step();
      idle();
      set_id(16'hD0E0, 16'h0010, 16'h0BAD, 1, 1, 3'd0, 3'd3, 3'd6, 1, 0);
      #2; chk("luh asserted", 16'(load_use_hazard), 16'h0001);
      step();
      exmem_reg_write = 1; exmem_rd_addr = 3'd3; exmem_result = 16'h0000;
      #2;
      chk("bubble valid", 16'(ex_valid), 16'h0000);
      chk("bubble instr", ex_instr, 16'h0800);
      chk("luh after bubble", 16'(load_use_hazard), 16'h0000);
      step();
      idle();
      memwb_reg_write = 1; memwb_rd_addr = 3'd3; memwb_result = 16'h4242;
      #2;
      chk("dep valid", 16'(ex_valid), 16'h0001);
      chk("dep reg2 fwd", ex_reg2, 16'h4242);
      step();

      // Stall refresh
      set_id(16'hD9A0, 16'h0001, 16'h0002, 1, 0, 3'd5, 3'd0, 3'd1, 1, 0);
      step();
      idle(); set_id(16'h1234, 16'h0, 16'h0, 0, 0, 3'd0, 3'd0, 3'd0, 1, 0);
      stall = 1; memwb_reg_write = 1; memwb_rd_addr = 3'd5; memwb_result = 16'hABCD;
      step();
      memwb_reg_write = 0;
      step();
      step();
      idle(); #2;
      chk("stall refresh reg1", ex_reg1, 16'hABCD);
      chk("stall held valid", 16'(ex_valid), 16'h0001);
      step();

      // Flush with stall
      set_id(16'hD9A0, 16'h0001, 16'h0002, 1, 1, 3'd1, 3'd2, 3'd3, 1, 0);
      step();
      stall = 1; flush = 1;
      step();
      idle(); #2;
      chk("flush valid", 16'(ex_valid), 16'h0000);
      chk("flush instr", ex_instr, 16'h0800);
      step();

      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step();
      end
      idle();
      step();
      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      if (!done) begin
         $display("FAIL timeout: got no end expected end of test");
         $fatal(1, "timeout");
      end
   end

endmodule
